booth_pp_reducer: RTL and testbench

- Pipelined carry-save reduction tree that consumes the 16 Booth partial products (64 bits each) from the radix-4 partial-product generator and produces the final 64-bit product.
- Sits directly downstream of the partial-product generator in the RISC-V PE multiply path.
- Uses a valid/ready handshake with full backpressure, a sideband tag, and a synchronous flush.

---
 rtl/pp_reduce_pkg.sv | 18 +
 rtl/booth_pp_reducer_csa_3to2.sv | 15 +
 rtl/booth_pp_reducer.sv | 178 +++++++++++++++++
 tb/tb_booth_pp_reducer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pp_reduce_pkg.sv
// Shared constants and row type for the Booth partial-product reduction tree.
package pp_reduce_pkg;

    localparam int unsigned NUM_PP     = 16;
    localparam int unsigned PP_W       = 64;
    localparam int unsigned PIPE_DEPTH = 3;

    // Row counts after each compression level
    localparam int unsigned L1_ROWS = 11;
    localparam int unsigned L2_ROWS = 8;
    localparam int unsigned L3_ROWS = 6;
    localparam int unsigned L4_ROWS = 4;
    localparam int unsigned L5_ROWS = 3;
    localparam int unsigned L6_ROWS = 2;

    typedef logic [PP_W-1:0] pp_row_t;

endpackage

// File: rtl/booth_pp_reducer_csa_3to2.sv
// 3:2 carry-save compressor; carry is pre-shifted and truncated to W bits.
module csa_3to2 #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    assign sum   = a ^ b ^ c;
    assign carry = {(a[W-2:0] & b[W-2:0]) | (a[W-2:0] & c[W-2:0]) | (b[W-2:0] & c[W-2:0]), 1'b0};

endmodule

// File: rtl/booth_pp_reducer.sv
// Three-stage carry-save reduction of 16 Booth rows to a 64-bit product with valid/ready flow.
// Optional op_count output enabled by defining PP_REDUCER_PERF_CNT_EN.
module booth_pp_reducer
    import pp_reduce_pkg::*;
#(
    parameter int unsigned TAG_W = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_PP*PP_W-1:0] pp_flat,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PP_W-1:0]        product,
    output logic [TAG_W-1:0]       out_tag
`ifdef PP_REDUCER_PERF_CNT_EN
    ,
    output logic [31:0]            op_count
`endif
);

    pp_row_t l0 [NUM_PP];
    pp_row_t l1 [L1_ROWS];
    pp_row_t l2 [L2_ROWS];
    pp_row_t l3 [L3_ROWS];
    pp_row_t l4 [L4_ROWS];
    pp_row_t l5 [L5_ROWS];
    pp_row_t l6 [L6_ROWS];
    pp_row_t sum_c;

    logic                   s1_valid_q, s1_valid_d;
    pp_row_t                s1_rows_q [L2_ROWS];
    pp_row_t                s1_rows_d [L2_ROWS];
    logic [TAG_W-1:0]       s1_tag_q, s1_tag_d;
    logic                   s2_valid_q, s2_valid_d;
    pp_row_t                s2_rows_q [L4_ROWS];
    pp_row_t                s2_rows_d [L4_ROWS];
    logic [TAG_W-1:0]       s2_tag_q, s2_tag_d;
    logic                   s3_valid_q, s3_valid_d;
    pp_row_t                s3_product_q, s3_product_d;
    logic [TAG_W-1:0]       s3_tag_q, s3_tag_d;

    logic in_fire, s2_adv, s3_adv, s3_drain;

    for (genvar i = 0; i < NUM_PP; i++) begin : g_unpack
        assign l0[i] = pp_flat[PP_W*i +: PP_W];
    end

    // Level 1: 16 -> 11
    for (genvar g = 0; g < NUM_PP/3; g++) begin : g_l1_csa
        csa_3to2 #(.W(PP_W)) u_csa (.a(l0[3*g]), .b(l0[3*g+1]), .c(l0[3*g+2]),
                                    .sum(l1[2*g]), .carry(l1[2*g+1]));
    end
    for (genvar g = 0; g < NUM_PP%3; g++) begin : g_l1_pass
        assign l1[2*(NUM_PP/3)+g] = l0[3*(NUM_PP/3)+g];
    end

    // Level 2: 11 -> 8
    for (genvar g = 0; g < L1_ROWS/3; g++) begin : g_l2_csa
        csa_3to2 #(.W(PP_W)) u_csa (.a(l1[3*g]), .b(l1[3*g+1]), .c(l1[3*g+2]),
                                    .sum(l2[2*g]), .carry(l2[2*g+1]));
    end
    for (genvar g = 0; g < L1_ROWS%3; g++) begin : g_l2_pass
        assign l2[2*(L1_ROWS/3)+g] = l1[3*(L1_ROWS/3)+g];
    end

    // Level 3: 8 -> 6, fed from S1
    for (genvar g = 0; g < L2_ROWS/3; g++) begin : g_l3_csa
        csa_3to2 #(.W(PP_W)) u_csa (.a(s1_rows_q[3*g]), .b(s1_rows_q[3*g+1]), .c(s1_rows_q[3*g+2]),
                                    .sum(l3[2*g]), .carry(l3[2*g+1]));
    end
    for (genvar g = 0; g < L2_ROWS%3; g++) begin : g_l3_pass
        assign l3[2*(L2_ROWS/3)+g] = s1_rows_q[3*(L2_ROWS/3)+g];
    end

    // Level 4: 6 -> 4
    for (genvar g = 0; g < L3_ROWS/3; g++) begin : g_l4_csa
        csa_3to2 #(.W(PP_W)) u_csa (.a(l3[3*g]), .b(l3[3*g+1]), .c(l3[3*g+2]),
                                    .sum(l4[2*g]), .carry(l4[2*g+1]));
    end
    for (genvar g = 0; g < L3_ROWS%3; g++) begin : g_l4_pass
        assign l4[2*(L3_ROWS/3)+g] = l3[3*(L3_ROWS/3)+g];
    end

    // Level 5: 4 -> 3, fed from S2
    for (genvar g = 0; g < L4_ROWS/3; g++) begin : g_l5_csa
        csa_3to2 #(.W(PP_W)) u_csa (.a(s2_rows_q[3*g]), .b(s2_rows_q[3*g+1]), .c(s2_rows_q[3*g+2]),
                                    .sum(l5[2*g]), .carry(l5[2*g+1]));
    end
    for (genvar g = 0; g < L4_ROWS%3; g++) begin : g_l5_pass
        assign l5[2*(L4_ROWS/3)+g] = s2_rows_q[3*(L4_ROWS/3)+g];
    end

    // Level 6: 3 -> 2, then carry-propagate add
    for (genvar g = 0; g < L5_ROWS/3; g++) begin : g_l6_csa
        csa_3to2 #(.W(PP_W)) u_csa (.a(l5[3*g]), .b(l5[3*g+1]), .c(l5[3*g+2]),
                                    .sum(l6[2*g]), .carry(l6[2*g+1]));
    end
    for (genvar g = 0; g < L5_ROWS%3; g++) begin : g_l6_pass
        assign l6[2*(L5_ROWS/3)+g] = l5[3*(L5_ROWS/3)+g];
    end

    assign sum_c = l6[0] + l6[1];

    // Handshake chain: readiness ripples combinationally back from out_ready
    always_comb begin
        s3_drain   = s3_valid_q & out_ready;
        s3_adv     = s2_valid_q & (~s3_valid_q | s3_drain);
        s2_adv     = s1_valid_q & (~s2_valid_q | s3_adv);
        in_ready   = ~s1_valid_q | s2_adv;
        in_fire    = in_valid & in_ready;

        s1_valid_d = in_fire | (s1_valid_q & ~s2_adv);
        s2_valid_d = s2_adv  | (s2_valid_q & ~s3_adv);
        s3_valid_d = s3_adv  | (s3_valid_q & ~s3_drain);
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            s3_valid_d = 1'b0;
        end

        s1_rows_d    = in_fire ? l2      : s1_rows_q;
        s1_tag_d     = in_fire ? in_tag  : s1_tag_q;
        s2_rows_d    = s2_adv  ? l4      : s2_rows_q;
        s2_tag_d     = s2_adv  ? s1_tag_q : s2_tag_q;
        s3_product_d = s3_adv  ? sum_c   : s3_product_q;
        s3_tag_d     = s3_adv  ? s2_tag_q : s3_tag_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            s3_valid_q   <= 1'b0;
            s1_tag_q     <= '0;
            s2_tag_q     <= '0;
            s3_tag_q     <= '0;
            s3_product_q <= '0;
            for (int i = 0; i < int'(L2_ROWS); i++) s1_rows_q[i] <= '0;
            for (int i = 0; i < int'(L4_ROWS); i++) s2_rows_q[i] <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s2_valid_q   <= s2_valid_d;
            s3_valid_q   <= s3_valid_d;
            s1_tag_q     <= s1_tag_d;
            s2_tag_q     <= s2_tag_d;
            s3_tag_q     <= s3_tag_d;
            s3_product_q <= s3_product_d;
            s1_rows_q    <= s1_rows_d;
            s2_rows_q    <= s2_rows_d;
        end
    end

    assign out_valid = s3_valid_q;
    assign product   = s3_product_q;
    assign out_tag   = s3_tag_q;

`ifdef PP_REDUCER_PERF_CNT_EN
    logic [31:0] op_count_q, op_count_d;

    // Completed-operation counter; survives flush, wraps naturally
    always_comb begin
        op_count_d = op_count_q;
        if (s3_drain) op_count_d = op_count_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) op_count_q <= '0;
        else        op_count_q <= op_count_d;
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_booth_pp_reducer.sv
// Scoreboard bench for booth_pp_reducer: random rows and Booth-encoded operands against an arithmetic model.
module tb_booth_pp_reducer;
    import pp_reduce_pkg::*;

    localparam int unsigned TW = 5;

    logic                   clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [NUM_PP*PP_W-1:0] pp_flat;
    logic [TW-1:0]          in_tag, out_tag;
    logic [PP_W-1:0]        product;
`ifdef PP_REDUCER_PERF_CNT_EN
    logic [31:0]            op_count;
`endif

    booth_pp_reducer #(.TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .pp_flat(pp_flat), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .product(product), .out_tag(out_tag)
`ifdef PP_REDUCER_PERF_CNT_EN
        , .op_count(op_count)
`endif
    );

    typedef struct packed { logic [63:0] p; logic [TW-1:0] t; } exp_t;
    exp_t sb[$];

    int          n_vec = 0;
    int          n_err = 0;
    int          n_acc = 0;
    int          n_stall = 0;
    int          rdy_mode = 1;
    logic [31:0] exp_count = '0;
    logic        hold_v;
    logic [63:0] hold_p;
    logic [TW-1:0] hold_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] sum_rows(input logic [NUM_PP*PP_W-1:0] f);
        logic [63:0] s = '0;
        for (int i = 0; i < 16; i++) s = s + f[64*i +: 64];
        return s;
    endfunction

    function automatic logic [NUM_PP*PP_W-1:0] rand_rows();
        logic [NUM_PP*PP_W-1:0] f;
        for (int i = 0; i < 16; i++) f[64*i +: 64] = {$urandom, $urandom};
        return f;
    endfunction

    // Radix-4 Booth rows for signed 32x32: digit = -2*b[2i+1] + b[2i] + b[2i-1]
    function automatic logic [NUM_PP*PP_W-1:0] booth_rows(input logic [31:0] a, input logic [31:0] b);
        logic [NUM_PP*PP_W-1:0] f;
        logic [32:0] bx;
        longint sa;
        int d;
        bx = {b, 1'b0};
        sa = longint'($signed(a));
        for (int i = 0; i < 16; i++) begin
            d = -2 * int'(bx[2*i+2]) + int'(bx[2*i+1]) + int'(bx[2*i]);
            f[64*i +: 64] = 64'(sa * longint'(d)) << (2*i);
        end
        return f;
    endfunction

    // Present one operation and hold it until accepted (or dropped by flush)
    task automatic send(input logic [NUM_PP*PP_W-1:0] f, input logic [TW-1:0] tag, input logic [63:0] exp);
        int  w = 0;
        bit  done = 0;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        pp_flat  = f;
        in_tag   = tag;
        while (!done) begin
            #4;
            if (flush) done = 1;
            else if (in_ready) begin
                e.p = exp;
                e.t = tag;
                sb.push_back(e);
                n_acc++;
                done = 1;
            end else begin
                n_stall++;
                w++;
                if (w > 200) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL accept_timeout: in_ready stuck at %b required 1", in_ready);
                    done = 1;
                end else @(negedge clk);
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic expect_latency(input string name);
        int i = 0;
        while (i < 10) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (out_valid) break;
            i++;
        end
        // Accepting edge counts as the first of PIPE_DEPTH register edges
        chk(name, 64'(i), 64'(PIPE_DEPTH - 1));
    endtask

    task automatic wait_drain();
        int w = 0;
        while (w < 200) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0 && !out_valid) break;
            w++;
        end
        chk("drain_left", 64'(sb.size()), 64'd0);
    endtask

    // Consumer ready pattern
    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: stability while stalled, and in-order compare on every transfer
    initial begin
        exp_t e;
        hold_v = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) hold_v = 1'b0;
            else begin
                if (hold_v) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_product", product, hold_p);
                    chk("hold_tag", 64'(out_tag), 64'(hold_t));
                end
                if (out_valid && out_ready) begin
                    exp_count = exp_count + 32'd1;
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_output: product %h tag %0d with empty scoreboard", product, out_tag);
                    end else begin
                        e = sb.pop_front();
                        chk("product", product, e.p);
                        chk("out_tag", 64'(out_tag), 64'(e.t));
                    end
                end
                hold_v = out_valid && !out_ready && !flush;
                hold_p = product;
                hold_t = out_tag;
                if (flush) sb.delete();
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_PP*PP_W-1:0] f;
        logic [31:0] a, b;
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; pp_flat = '0; in_tag = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_product", product, 64'd0);
        chk("reset_out_tag", 64'(out_tag), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #2 chk("reset_in_ready", 64'(in_ready), 64'd1);
`ifdef PP_REDUCER_PERF_CNT_EN
        chk("reset_op_count", 64'(op_count), 64'd0);
`endif

        // Zero rows, held until consumer ready
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        send('0, 5'd3, 64'd0);
        expect_latency("latency_zero");
        repeat (5) @(negedge clk);
        rdy_mode = 1;
        wait_drain();

        // Wrap cases
        f = '0;
        f[63:0]   = 64'hFFFF_FFFF_FFFF_FFFF;
        f[127:64] = 64'd1;
        send(f, 5'd1, 64'd0);
        for (int i = 0; i < 16; i++) f[64*i +: 64] = 64'd1;
        send(f, 5'd2, 64'h10);
        idle();
        wait_drain();

        // Random rows, random gaps and backpressure
        rdy_mode = 2;
        for (int k = 0; k < 200; k++) begin
            f = rand_rows();
            send(f, 5'($urandom), sum_rows(f));
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        rdy_mode = 1;
        wait_drain();

        // Booth end-to-end, back-to-back at full rate
        repeat (2) @(negedge clk);
        n_stall = 0;
        send(booth_rows(32'hFFFF_FFFF, 32'hFFFF_FFFF), 5'd4, 64'd1);
        send(booth_rows(32'h8000_0000, 32'h8000_0000), 5'd5, 64'h4000_0000_0000_0000);
        for (int k = 0; k < 1000; k++) begin
            a = $urandom;
            b = $urandom;
            send(booth_rows(a, b), 5'(k), 64'(longint'($signed(a)) * longint'($signed(b))));
        end
        idle();
        chk("b2b_stalls", 64'(n_stall), 64'd0);
        wait_drain();

        // Backpressure: only three fit while the consumer stalls
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        n_acc = 0;
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    f = rand_rows();
                    send(f, 5'(20 + k), sum_rows(f));
                end
                idle();
            end
            begin
                repeat (10) @(negedge clk);
                #1;
                chk("bp_accepted", 64'(n_acc), 64'd3);
                chk("bp_in_ready", 64'(in_ready), 64'd0);
                rdy_mode = 1;
            end
        join
        wait_drain();

        // Flush with a full pipe, then flush racing an input
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            f = rand_rows();
            send(f, 5'(8 + k), sum_rows(f));
        end
        idle();
        #1 chk("pre_flush_valid", 64'(out_valid), 64'd1);
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        #1;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; pp_flat = rand_rows(); in_tag = 5'd30;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        rdy_mode = 1;
        f = rand_rows();
        send(f, 5'd17, sum_rows(f));
        expect_latency("latency_after_flush");
        wait_drain();

        // Asynchronous reset with S2 and S3 occupied
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            f = rand_rows();
            send(f, 5'(12 + k), sum_rows(f));
        end
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_product", product, 64'd0);
        chk("rst_mid_out_tag", 64'(out_tag), 64'd0);
        sb.delete();
        exp_count = '0;
`ifdef PP_REDUCER_PERF_CNT_EN
        chk("rst_mid_op_count", 64'(op_count), 64'd0);
`endif
        @(negedge clk);
        #2 rst_n = 1'b1;
        rdy_mode = 2;
        repeat (6) @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            f = rand_rows();
            send(f, 5'($urandom), sum_rows(f));
        end
        idle();
        rdy_mode = 1;
        wait_drain();
`ifdef PP_REDUCER_PERF_CNT_EN
        chk("op_count_final", 64'(op_count), 64'(exp_count));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
